// File: rtl/da_spi_pkg.sv
// da_spi_pkg: shared state encoding, field positions and frame status type
// for the DA SPI slave.
package da_spi_pkg;

  localparam int BYTE_W       = 8;
  localparam int INSTR_RW_BIT = 7;

  typedef enum logic [2:0] {
    IDLE,
    INSTR,
    WDATA,
    RDATA,
    DRAIN
  } state_e;

  typedef struct packed {
    logic done;
    logic err;
  } frame_status_t;

endpackage

// File: rtl/da_spi_sync_edge.sv
// da_spi_sync_edge: multi-flop synchronizer followed by a registered edge
// detector; lvl_o is time-aligned with the rise/fall pulses.
module da_spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              rise_q;
  logic              fall_q;

  // Reset to low so a CS already low when reset drops produces no cs_fall.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      prev_q <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~prev_q;
      fall_q <= ~sync_q[STAGES-1] & prev_q;
    end
  end

  assign lvl_o  = prev_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/da_spi_slave.sv
// da_spi_slave: mode-0 SPI responder writing an auto-incrementing register file.
// SDO read-back is built only when DA_SPI_SLV_READBACK_EN is defined.
module da_spi_slave
  import da_spi_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              GCLK,
  input  logic              Cir_resetn,
  input  logic              DA_SCLK_IN,
  input  logic              DA_CS_IN,
  input  logic              DA_SPI_IN,
  output logic              DA_SDO_OUT,
  output logic              DA_SDO_OE,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              frame_done,
  output logic              frame_err,
  output logic [7:0]        byte_cnt
);
  // state | meaning
  // IDLE  | CS high, waiting for cs_fall
  // INSTR | shifting in the instruction byte
  // WDATA | each full byte written to regfile[addr], addr++
  // RDATA | regfile[addr] shifted out on SDO, addr++ per byte
  // DRAIN | illegal instruction, bits ignored until CS rises

  localparam int DEPTH = 2**ADDR_W;
`ifdef DA_SPI_SLV_READBACK_EN
  localparam state_e READ_ST = RDATA;
`else
  localparam state_e READ_ST = DRAIN;
`endif

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;

  da_spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk_i(GCLK), .rst_ni(Cir_resetn), .async_i(DA_SCLK_IN),
    .lvl_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall));
  da_spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk_i(GCLK), .rst_ni(Cir_resetn), .async_i(DA_CS_IN),
    .lvl_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall));
  da_spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk_i(GCLK), .rst_ni(Cir_resetn), .async_i(DA_SPI_IN),
    .lvl_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall));

  logic unused_sync;
  assign unused_sync = ^{sclk_lvl, mosi_rise, mosi_fall};

  state_e              state_q, state_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-2:0]   rx_q, rx_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          byte_cnt_q, byte_cnt_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [BYTE_W-1:0]   wr_data_q, wr_data_d;
  frame_status_t       status_q, status_d;
  logic [BYTE_W-1:0]   rx_byte;
  logic                sclk_rise_v, sclk_fall_v;
  logic [BYTE_W-1:0]   regfile_q [DEPTH];

  assign rx_byte     = {rx_q, mosi_lvl};
  assign sclk_rise_v = sclk_rise & ~cs_lvl & (state_q != IDLE);
  assign sclk_fall_v = sclk_fall & ~cs_lvl & (state_q != IDLE);

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_d       = rx_q;
    addr_d     = addr_q;
    byte_cnt_d = byte_cnt_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    status_d   = '0;
    if (cs_fall) begin
      // A fall outside IDLE means the previous frame never closed cleanly.
      status_d.err = (state_q != IDLE);
      state_d      = INSTR;
      bit_cnt_d    = '0;
      byte_cnt_d   = '0;
    end else if (cs_rise) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      case (state_q)
        INSTR, WDATA, RDATA: begin
          status_d.err  = (bit_cnt_q != 3'd0);
          status_d.done = (bit_cnt_q == 3'd0);
        end
        DRAIN:   status_d.err = 1'b1;
        default: ;
      endcase
    end else if (sclk_rise_v) begin
      rx_d      = rx_byte[BYTE_W-2:0];
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        case (state_q)
          INSTR: begin
            addr_d = rx_byte[ADDR_W-1:0];
            if ((rx_byte[BYTE_W-2:0] >> ADDR_W) != '0) state_d = DRAIN;
            else if (rx_byte[INSTR_RW_BIT])            state_d = READ_ST;
            else                                       state_d = WDATA;
          end
          WDATA: begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = rx_byte;
            addr_d    = addr_q + 1'b1;
            if (byte_cnt_q != 8'hFF) byte_cnt_d = byte_cnt_q + 8'd1;
          end
          default: ;
        endcase
      end
    end else if (sclk_fall_v && state_q == RDATA && bit_cnt_q == 3'd0) begin
      addr_d = addr_q + 1'b1;
    end
  end

  always_ff @(posedge GCLK or negedge Cir_resetn) begin
    if (!Cir_resetn) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      rx_q       <= '0;
      addr_q     <= '0;
      byte_cnt_q <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      status_q   <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_q       <= rx_d;
      addr_q     <= addr_d;
      byte_cnt_q <= byte_cnt_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      status_q   <= status_d;
    end
  end

  always_ff @(posedge GCLK or negedge Cir_resetn) begin
    if (!Cir_resetn) begin
      for (int i = 0; i < DEPTH; i++) regfile_q[i] <= '0;
    end else if (wr_en_q) begin
      regfile_q[wr_addr_q] <= wr_data_q;
    end
  end

`ifdef DA_SPI_SLV_READBACK_EN
  logic [BYTE_W-1:0] rd_sh_q;
  logic [BYTE_W-1:0] rd_byte;
  logic              sdo_q, oe_q;

  assign rd_byte = regfile_q[addr_q];

  // Byte boundary falls load the next byte; the others shift one bit out.
  always_ff @(posedge GCLK or negedge Cir_resetn) begin
    if (!Cir_resetn) begin
      rd_sh_q <= '0;
      sdo_q   <= 1'b0;
      oe_q    <= 1'b0;
    end else if (cs_fall || cs_rise) begin
      sdo_q <= 1'b0;
      oe_q  <= 1'b0;
    end else if (sclk_fall_v && state_q == RDATA) begin
      if (bit_cnt_q == 3'd0) begin
        sdo_q   <= rd_byte[BYTE_W-1];
        rd_sh_q <= rd_byte << 1;
        oe_q    <= 1'b1;
      end else begin
        sdo_q   <= rd_sh_q[BYTE_W-1];
        rd_sh_q <= rd_sh_q << 1;
      end
    end
  end

  assign DA_SDO_OUT = sdo_q;
  assign DA_SDO_OE  = oe_q;
`else
  logic unused_rf;
  always_comb begin
    unused_rf = 1'b0;
    for (int i = 0; i < DEPTH; i++) unused_rf = unused_rf ^ (^regfile_q[i]);
  end

  assign DA_SDO_OUT = 1'b0;
  assign DA_SDO_OE  = 1'b0;
`endif

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign frame_done = status_q.done;
  assign frame_err  = status_q.err;
  assign byte_cnt   = byte_cnt_q;

endmodule

// File: tb/tb_da_spi_slave.sv
// tb_da_spi_slave: drives mode-0 SPI frames and checks writes, frame status,
// byte count and SDO against a frame-level reference model.
module tb_da_spi_slave;

  localparam int AW = 4;
  localparam int HP = 60;
`ifdef DA_SPI_SLV_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic GCLK = 1'b0;
  logic Cir_resetn = 1'b0;
  logic sclk = 1'b0;
  logic cs = 1'b1;
  logic mosi = 1'b0;
  logic sdo, sdo_oe, wr_en, frame_done, frame_err;
  logic [AW-1:0] wr_addr;
  logic [7:0] wr_data, byte_cnt;

  int n_tests = 0;
  int n_fail = 0;
  logic [AW+7:0] exp_wr[$];
  logic [AW+7:0] got_wr[$];
  int exp_done, exp_err, exp_bc;
  int got_done = 0;
  int got_err = 0;
  logic [7:0] model_rf[2**AW];
  logic [7:0] fb_q[$];
  logic sdo_samp[$];
  logic oe_samp[$];
  logic in_read = 1'b0;

  da_spi_slave #(.ADDR_W(AW), .SYNC_STAGES(2)) dut (
    .GCLK(GCLK), .Cir_resetn(Cir_resetn), .DA_SCLK_IN(sclk), .DA_CS_IN(cs),
    .DA_SPI_IN(mosi), .DA_SDO_OUT(sdo), .DA_SDO_OE(sdo_oe), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .frame_done(frame_done),
    .frame_err(frame_err), .byte_cnt(byte_cnt));

  always #5 GCLK = ~GCLK;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge GCLK) begin
    if (Cir_resetn) begin
      if (wr_en) begin
        got_wr.push_back({wr_addr, wr_data});
        n_tests++;
        if (exp_wr.size() == 0) begin
          n_fail++;
          $display("FAIL wr_unexpected: got addr %0d data 0x%02h, expected no write", wr_addr, wr_data);
        end else begin
          logic [AW+7:0] e;
          e = exp_wr.pop_front();
          if ({wr_addr, wr_data} !== e) begin
            n_fail++;
            $display("FAIL wr_mismatch: got addr/data 0x%03h, expected 0x%03h", {wr_addr, wr_data}, e);
          end
        end
      end
      if (frame_done) got_done++;
      if (frame_err) got_err++;
      if (!(RB && in_read)) begin
        n_tests++;
        if (sdo !== 1'b0 || sdo_oe !== 1'b0) begin
          n_fail++;
          $display("FAIL sdo_idle: got sdo %b oe %b, expected 0 0", sdo, sdo_oe);
        end
      end
    end
  end

  function automatic int got_at(input int i);
    return (got_wr.size() > i) ? int'(got_wr[i]) : -1;
  endfunction

  // Frame-level model: what a frame of nbits (from fb_q) must produce.
  task automatic model_frame(input int nbits);
    logic [7:0] instr;
    int nfull, part, a;
    exp_wr.delete();
    exp_bc = 0; exp_done = 0; exp_err = 0;
    nfull = nbits / 8;
    part  = nbits % 8;
    if (nfull == 0) begin
      if (part == 0) exp_done = 1; else exp_err = 1;
      return;
    end
    instr = fb_q[0];
    if (int'(instr % 128) >= 2**AW || (instr >= 128 && !RB)) begin
      exp_err = 1;
      return;
    end
    if (part == 0) exp_done = 1; else exp_err = 1;
    if (instr >= 128) return;
    for (int k = 1; k < nfull; k++) begin
      a = (int'(instr) + k - 1) % (2**AW);
      exp_wr.push_back({AW'(a), fb_q[k]});
      model_rf[a] = fb_q[k];
    end
    exp_bc = (nfull - 1 > 255) ? 255 : nfull - 1;
  endtask

  task automatic cs_low();
    cs = 1'b0;
    #(HP);
  endtask

  task automatic send_bits(input int from, input int to);
    logic [7:0] b;
    for (int i = from; i < to; i++) begin
      b = fb_q[i / 8];
      mosi = b[7 - i % 8];
      #(HP);
      sclk = 1'b1;
      sdo_samp.push_back(sdo);
      oe_samp.push_back(sdo_oe);
      #(HP);
      sclk = 1'b0;
    end
  endtask

  task automatic cs_high();
    #(2 * HP);
    cs = 1'b1;
    #(2 * HP);
  endtask

  task automatic end_check(input string nm);
    repeat (4) @(posedge GCLK);
    #2;
    chk({nm, " done"}, got_done, exp_done);
    chk({nm, " err"}, got_err, exp_err);
    chk({nm, " missing_wr"}, exp_wr.size(), 0);
    chk({nm, " byte_cnt"}, int'(byte_cnt), exp_bc);
  endtask

  task automatic send_frame(input int nbits, input string nm);
    model_frame(nbits);
    got_wr.delete(); sdo_samp.delete(); oe_samp.delete();
    got_done = 0; got_err = 0;
    in_read = (nbits >= 8 && fb_q[0] >= 128);
    cs_low();
    send_bits(0, nbits);
    cs_high();
    end_check(nm);
`ifdef DA_SPI_SLV_READBACK_EN
    if (nbits >= 8 && fb_q[0] >= 128 && int'(fb_q[0] % 128) < 2**AW) begin
      for (int j = 0; j < nbits; j++) begin
        logic [7:0] rb;
        if (j < 8) begin
          chk({nm, " oe_instr"}, int'(oe_samp[j]), 0);
        end else begin
          rb = model_rf[(int'(fb_q[0] % 128) + (j - 8) / 8) % (2**AW)];
          chk({nm, " sdo_bit"}, int'(sdo_samp[j]), int'(rb[7 - (j - 8) % 8]));
          chk({nm, " oe_data"}, int'(oe_samp[j]), 1);
        end
      end
    end
`endif
    in_read = 1'b0;
  endtask

  initial begin
    logic [7:0] sdo_byte;
    logic [15:0] oe_word;
    for (int i = 0; i < 2**AW; i++) model_rf[i] = 8'h00;
    #22;
    chk("rst0 sdo", int'(sdo), 0);
    chk("rst0 oe", int'(sdo_oe), 0);
    chk("rst0 wr_en", int'(wr_en), 0);
    chk("rst0 wr_addr", int'(wr_addr), 0);
    chk("rst0 wr_data", int'(wr_data), 0);
    chk("rst0 done", int'(frame_done), 0);
    chk("rst0 err", int'(frame_err), 0);
    chk("rst0 byte_cnt", int'(byte_cnt), 0);
    #10;
    Cir_resetn = 1'b1;
    #(4 * HP);

    fb_q = {8'h03, 8'hA5, 8'h5A};
    send_frame(24, "wr3");
    chk("wr3 count", got_wr.size(), 2);
    chk("wr3 w0", got_at(0), 12'h3A5);
    chk("wr3 w1", got_at(1), 12'h45A);
    chk("wr3 bc_lit", int'(byte_cnt), 2);
    chk("wr3 model_rf3", int'(model_rf[3]), 8'hA5);

    fb_q = {8'h0F, 8'h11, 8'h22};
    send_frame(24, "wrap");
    chk("wrap w0", got_at(0), 12'hF11);
    chk("wrap w1", got_at(1), 12'h022);

    fb_q = {8'h06, 8'h3C, 8'h9A, 8'h00};
    send_frame(21, "partial");
    chk("partial count", got_wr.size(), 1);
    chk("partial w0", got_at(0), 12'h63C);
    chk("partial model_err", exp_err, 1);
    chk("partial bc_lit", int'(byte_cnt), 1);

    fb_q = {8'h40, 8'h12};
    send_frame(16, "illegal");
    chk("illegal count", got_wr.size(), 0);
    chk("illegal model_err", exp_err, 1);

    fb_q = {8'h02, 8'hC3};
    send_frame(16, "rb_wr");
    fb_q = {8'h82, 8'h00};
    send_frame(16, "rb_rd");
    sdo_byte = '0;
    oe_word = '0;
    for (int j = 0; j < 16; j++) oe_word[j] = oe_samp[j];
    for (int j = 8; j < 16; j++) sdo_byte[15 - j] = sdo_samp[j];
`ifdef DA_SPI_SLV_READBACK_EN
    chk("rb_rd sdo_byte", int'(sdo_byte), 8'hC3);
    chk("rb_rd oe_window", int'(oe_word), 16'hFF00);
`else
    chk("rb_rd sdo_byte", int'(sdo_byte), 0);
    chk("rb_rd oe_window", int'(oe_word), 0);
    chk("rb_rd model_err", exp_err, 1);
`endif

    for (int f = 0; f < 40; f++) begin
      int r, nd, part, nb;
      logic [7:0] instr;
      r = int'($urandom_range(0, 9));
      if (r == 0)      instr = 8'($urandom_range(16, 127));
      else if (r == 1) instr = 8'(128 + $urandom_range(0, 15));
      else             instr = 8'($urandom_range(0, 15));
      nd = int'($urandom_range(0, 5));
      part = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
      nb = 8 + nd * 8 + part;
      if (r == 2) nb = int'($urandom_range(0, 7));
      fb_q.delete();
      fb_q.push_back(instr);
      for (int k = 0; k <= nd; k++) fb_q.push_back(8'($urandom));
      send_frame(nb, "rnd");
    end

    fb_q.delete();
    fb_q.push_back(8'h00);
    for (int k = 0; k < 257; k++) fb_q.push_back(8'($urandom));
    send_frame(8 + 257 * 8, "sat");
    chk("sat bc_lit", int'(byte_cnt), 255);

    fb_q = {8'h05, 8'hF0};
    got_wr.delete(); exp_wr.delete();
    got_done = 0; got_err = 0;
    exp_done = 0; exp_err = 0; exp_bc = 0;
    cs_low();
    send_bits(0, 12);
    Cir_resetn = 1'b0;
    #20;
    chk("rstmid sdo", int'(sdo), 0);
    chk("rstmid oe", int'(sdo_oe), 0);
    chk("rstmid wr_en", int'(wr_en), 0);
    chk("rstmid wr_addr", int'(wr_addr), 0);
    chk("rstmid wr_data", int'(wr_data), 0);
    chk("rstmid done", int'(frame_done), 0);
    chk("rstmid err", int'(frame_err), 0);
    chk("rstmid byte_cnt", int'(byte_cnt), 0);
    for (int i = 0; i < 2**AW; i++) model_rf[i] = 8'h00;
    #10;
    Cir_resetn = 1'b1;
    #(HP);
    send_bits(12, 16);
    cs_high();
    end_check("rstmid");
    chk("rstmid count", got_wr.size(), 0);

    fb_q = {8'h00, 8'h7E};
    send_frame(16, "post_rst");
    chk("post_rst w0", got_at(0), 12'h07E);
    chk("post_rst bc_lit", int'(byte_cnt), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
